trace_capture_buffer: RTL and testbench
=======================================

Name: trace_capture_buffer

Overview:
- Sits directly downstream of the core wrapper's trace port and consumes the 36-bit trace_valid/trace_data stream.
- Holds the most recent DEPTH words in a circular buffer while armed.
- On trap, captures POST_TRIG further words, freezes, then drains the captured window oldest-first over a valid/ready read port.
- Used by both the simulation bench and on-chip debug to replace the file-based trace dump.

Parameters:
- DATA_W, 36, trace word width; must match the trace_data width.
- DEPTH, 256, buffer entries; power of two, at least 2. ADDR_W = $clog2(DEPTH).
- POST_TRIG, 64, words captured after the trigger; legal range 0..DEPTH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; starts or restarts a capture.
- trace_valid  in  1  trace word strobe from the core.
- trace_data  in  DATA_W  trace word.
- trap  in  1  trigger, level-sensitive; only the first high cycle in ARMED has an effect.
- rd_valid  out  1  rd_data holds a captured word.
- rd_ready  in  1  consumer accepts the word.
- rd_data  out  DATA_W  captured word, oldest first.
- level  out  ADDR_W+1  words stored (ARMED/POST) or words remaining to read (READ).
- state  out  2  IDLE=0, ARMED=1, POST=2, READ=3.

Behaviour:
- Reset: clk single clock, resetn asynchronous active-low.
  - While resetn is low: state=IDLE, rd_valid=0, rd_data=0, level=0; all pointers and counters cleared.
  - Reset asserted mid-operation aborts immediately; the in-flight capture is lost.
- IDLE:
  - trace_valid and trap are ignored.
  - arm -> ARMED; wr_ptr, level and post_cnt are cleared.
- ARMED:
  - Each trace_valid writes trace_data at wr_ptr; wr_ptr increments modulo DEPTH.
  - level increments and saturates at DEPTH; once full, the oldest entry is overwritten.
  - trap -> POST, or -> READ if POST_TRIG=0.
  - If trap and trace_valid coincide, that word is written and counts as pre-trigger.
  - arm restarts the capture: pointers and level are cleared and the state stays ARMED; this takes priority over trap.
- POST:
  - Writes and level behave as in ARMED; post_cnt counts writes.
  - The write that brings post_cnt to POST_TRIG moves the block to READ on the next edge.
  - trap is ignored. arm restarts the capture into ARMED.
- READ:
  - Entry: rd_ptr = (wr_ptr - level) mod DEPTH, which is the oldest word.
  - RAM read is synchronous (1 cycle). A one-entry output register prefetches, so the first rd_valid is asserted 2 cycles after entry.
  - Handshake: a transfer occurs when rd_valid && rd_ready.
    - rd_data and rd_valid stay stable while rd_valid && !rd_ready.
    - Sustained rd_ready gives one word per cycle with no bubbles after the first.
  - level decrements on each transfer. When the last word transfers, rd_valid falls and the next state is IDLE.
  - arm, trap and trace_valid are ignored; trace words arriving in READ are dropped.
  - A trigger with level=0 enters READ and returns to IDLE without asserting rd_valid.
- Width rules:
  - Pointers are ADDR_W bits and wrap naturally.
  - level and post_cnt are ADDR_W+1 bits, so level=DEPTH is representable.

Decomposition:
- Package trace_pkg holds:
  - TRACE_W=36.
  - The state encoding as a typedef enum (IDLE, ARMED, POST, READ).
- Sub-module trace_ram:
  - Simple dual-port RAM, DEPTH x DATA_W, one write port and one synchronous-read port, no reset on the array.
  - Kept separate so FPGA block-RAM inference stays clean.
- The FSM, pointers, counters and output register live in trace_capture_buffer.

Test Plan (DEPTH=8, POST_TRIG=3):
- Basic capture: arm; words 0x1..0x5; trap with no word; words 0x6..0x8.
  -> state goes to READ after 0x8. With rd_ready=1, reads are 0x1..0x8 in order. level counts 8 down to 0, then state=IDLE.
- Wrap: arm; words 0x1..0xC; trap; words 0xD..0xF.
  -> reads are exactly 0x8..0xF; level=8 on entry to READ.
- Coincident trigger: arm; word 0x1; word 0x2 with trap high in the same cycle; words 0x3..0x5.
  -> reads are 0x1..0x5; level=5 on entry.
- Backpressure: same stimulus as basic capture, rd_ready toggled every cycle.
  -> rd_data is held while stalled; 8 transfers of 0x1..0x8 with no duplicates or losses.
- Control edge cases:
  - trap in IDLE -> no state change.
  - arm during POST after 2 post words -> state=ARMED, level=0; the next capture reads back correctly.
  - trace_valid during READ -> ignored; read sequence unchanged.
- Async reset: assert resetn low mid-POST, between clock edges.
  -> state=IDLE, rd_valid=0, level=0 before the next edge. After release, the block stays IDLE until arm.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture buffer: trace word width and
// the controller state encoding exposed on the state output.
package trace_pkg;

  localparam int TRACE_W = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    READ  = 2'd3
  } state_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port storage for captured trace words: one write port and
// one registered read port with read enable. The array has no reset so it
// maps directly onto block RAM; the read register holds its value while
// i_rd_en is low, which the read pipeline relies on during stalls.
module trace_ram #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Synchronous read port; output holds when not enabled.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular trace capture: records the most recent DEPTH words while armed,
// keeps POST_TRIG more after a trap, then drains the window oldest-first
// over a valid/ready port. Reading is a two-stage pipeline (RAM read
// register, then a one-entry output register) so a sustained rd_ready
// yields one word per cycle.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = TRACE_W,
  parameter int DEPTH     = 256,
  parameter int POST_TRIG = 64,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              trace_valid,
  input  logic [DATA_W-1:0] trace_data,
  input  logic              trap,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] PTR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH_L     = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   POST_TRIG_L = POST_TRIG[ADDR_W:0];

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_next;
  logic [ADDR_W:0]     r_level, w_level_next;
  logic [ADDR_W:0]     r_post_cnt, w_post_next;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_issue_left;
  logic                r_q_valid;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_wr_en;
  logic                w_enter_read;
  logic                w_out_fire;
  logic                w_out_load;
  logic                w_rd_en;
  logic [DATA_W-1:0]   w_ram_q;

  // Read pipeline: the output register refills from the RAM stage whenever
  // it is empty or being consumed, and a new RAM read is issued whenever the
  // RAM stage is empty or moving forward.
  assign w_out_fire = r_rd_valid & rd_ready;
  assign w_out_load = r_q_valid & (~r_rd_valid | w_out_fire);
  assign w_rd_en    = (r_state == READ) && (r_issue_left != '0) &&
                      (~r_q_valid | w_out_load);

  trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (trace_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  // Next-state and capture bookkeeping; arm restarts take priority over trap.
  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_level_next  = r_level;
    w_post_next   = r_post_cnt;
    w_wr_en       = 1'b0;
    w_enter_read  = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_next  = ARMED;
          w_wr_ptr_next = '0;
          w_level_next  = '0;
          w_post_next   = '0;
        end
      end
      ARMED, POST: begin
        if (arm) begin
          w_state_next  = ARMED;
          w_wr_ptr_next = '0;
          w_level_next  = '0;
          w_post_next   = '0;
        end else begin
          if (trace_valid) begin
            w_wr_en       = 1'b1;
            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
            if (r_level != DEPTH_L) begin
              w_level_next = r_level + CNT_ONE;
            end
            if (r_state == POST) begin
              w_post_next = r_post_cnt + CNT_ONE;
            end
          end
          if (r_state == ARMED) begin
            if (trap) begin
              if (POST_TRIG == 0) begin
                w_state_next = READ;
                w_enter_read = 1'b1;
              end else begin
                w_state_next = POST;
                w_post_next  = '0;
              end
            end
          end else if (trace_valid && (w_post_next == POST_TRIG_L)) begin
            w_state_next = READ;
            w_enter_read = 1'b1;
          end
        end
      end
      READ: begin
        if (w_out_fire) begin
          w_level_next = r_level - CNT_ONE;
        end
        if ((r_level == '0) || ((r_level == CNT_ONE) && w_out_fire)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Controller registers; on READ entry the read pointer starts at the oldest
  // stored word, derived from the pointer and level after the final write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_level      <= '0;
      r_post_cnt   <= '0;
      r_rd_ptr     <= '0;
      r_issue_left <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_level    <= w_level_next;
      r_post_cnt <= w_post_next;
      if (w_enter_read) begin
        r_rd_ptr     <= w_wr_ptr_next - w_level_next[ADDR_W-1:0];
        r_issue_left <= w_level_next;
      end else if (w_rd_en) begin
        r_rd_ptr     <= r_rd_ptr + PTR_ONE;
        r_issue_left <= r_issue_left - CNT_ONE;
      end
    end
  end

  // Read pipeline valid bits and output data register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q_valid  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_state_next != READ) begin
        r_q_valid <= 1'b0;
      end else if (w_rd_en) begin
        r_q_valid <= 1'b1;
      end else if (w_out_load) begin
        r_q_valid <= 1'b0;
      end

      if (w_state_next != READ) begin
        r_rd_valid <= 1'b0;
      end else if (w_out_load) begin
        r_rd_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_rd_valid <= 1'b0;
      end

      if (w_out_load) begin
        r_rd_data <= w_ram_q;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign level    = r_level;
  assign state    = r_state;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer with DEPTH=8, POST_TRIG=3.
// A per-cycle vector table covers the basic capture and read-out; hand-written
// sequences cover wrap, coincident trigger, backpressure, restart and reset.
module tb_trace_capture_buffer;

  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          resetn;
  logic          arm;
  logic          trace_valid;
  logic [DW-1:0] trace_data;
  logic          trap;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [3:0]    level;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          arm;
    logic          tv;
    logic [DW-1:0] data;
    logic          trap;
    logic          rdy;
    logic [1:0]    st;
    logic          rv;
    logic [DW-1:0] rd;
    logic [3:0]    lvl;
  } vec_t;

  vec_t vecs[21];

  trace_capture_buffer #(
    .DATA_W    (DW),
    .DEPTH     (8),
    .POST_TRIG (3)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .arm         (arm),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trap        (trap),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs change on negedge, outputs sampled on the next negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic t);
    trace_valid = 1'b1;
    trace_data  = d;
    trap        = t;
    cyc();
    trace_valid = 1'b0;
    trap        = 1'b0;
  endtask

  task automatic do_trap();
    trap = 1'b1;
    cyc();
    trap = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  // Drain n words expected to be first, first+1, ...; optionally toggling
  // rd_ready and checking that stalled outputs are held.
  task automatic drain(input string nm, input logic [DW-1:0] first, input int n,
                       input bit toggle);
    int            got = 0;
    int            budget = 0;
    bit            stalled = 1'b0;
    bit            tgl = 1'b0;
    logic [DW-1:0] held = '0;
    while (state != 2'd3 && budget < 10) begin
      cyc();
      budget++;
    end
    chk({nm, " entry state"}, 64'(state), 64'd3);
    chk({nm, " entry level"}, 64'(level), 64'(n));
    budget = 0;
    while (got < n && budget < 100) begin
      if (stalled) begin
        chk({nm, " hold valid"}, 64'(rd_valid), 64'd1);
        chk({nm, " hold data"}, 64'(rd_data), 64'(held));
      end
      rd_ready = toggle ? tgl : 1'b1;
      tgl      = ~tgl;
      stalled  = rd_valid && !rd_ready;
      held     = rd_data;
      if (rd_valid && rd_ready) begin
        $display("%s xfer %0d data %0h level %0d", nm, got, rd_data, level);
        chk({nm, " data"}, 64'(rd_data), 64'(first + DW'(got)));
        chk({nm, " level"}, 64'(level), 64'(n - got));
        got++;
      end
      cyc();
      budget++;
    end
    rd_ready = 1'b0;
    chk({nm, " transfer count"}, 64'(got), 64'(n));
    chk({nm, " end state"}, 64'(state), 64'd0);
    chk({nm, " end valid"}, 64'(rd_valid), 64'd0);
    chk({nm, " end level"}, 64'(level), 64'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    arm         = 1'b0;
    trace_valid = 1'b0;
    trace_data  = '0;
    trap        = 1'b0;
    rd_ready    = 1'b0;

    // Basic capture table: arm, 0x1..0x5, trap, 0x6..0x8, read with
    // rd_ready=1 while stray trace words arrive, then a trap in IDLE.
    vecs[0] = '{1'b1, 1'b0, 36'h0, 1'b0, 1'b0, 2'd1, 1'b0, 36'h0, 4'd0};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b0, 1'b1, DW'(i), 1'b0, 1'b0, 2'd1, 1'b0, 36'h0, 4'(i)};
    vecs[6]  = '{1'b0, 1'b0, 36'h0, 1'b1, 1'b0, 2'd2, 1'b0, 36'h0, 4'd5};
    vecs[7]  = '{1'b0, 1'b1, 36'h6, 1'b0, 1'b0, 2'd2, 1'b0, 36'h0, 4'd6};
    vecs[8]  = '{1'b0, 1'b1, 36'h7, 1'b0, 1'b0, 2'd2, 1'b0, 36'h0, 4'd7};
    vecs[9]  = '{1'b0, 1'b1, 36'h8, 1'b0, 1'b0, 2'd3, 1'b0, 36'h0, 4'd8};
    vecs[10] = '{1'b0, 1'b1, 36'hAA, 1'b0, 1'b1, 2'd3, 1'b0, 36'h0, 4'd8};
    for (int i = 11; i <= 18; i++)
      vecs[i] = '{1'b0, (i <= 13), 36'hAA, 1'b0, 1'b1, 2'd3, 1'b1, DW'(i - 10), 4'(19 - i)};
    vecs[19] = '{1'b0, 1'b0, 36'h0, 1'b0, 1'b1, 2'd0, 1'b0, 36'h0, 4'd0};
    vecs[20] = '{1'b0, 1'b1, 36'h55, 1'b1, 1'b0, 2'd0, 1'b0, 36'h0, 4'd0};

    @(negedge clk);
    @(negedge clk);
    chk("reset state", 64'(state), 64'd0);
    chk("reset valid", 64'(rd_valid), 64'd0);
    chk("reset data", 64'(rd_data), 64'd0);
    chk("reset level", 64'(level), 64'd0);
    resetn = 1'b1;
    cyc();
    chk("idle after release", 64'(state), 64'd0);

    for (int i = 0; i < 21; i++) begin
      arm         = vecs[i].arm;
      trace_valid = vecs[i].tv;
      trace_data  = vecs[i].data;
      trap        = vecs[i].trap;
      rd_ready    = vecs[i].rdy;
      cyc();
      $display("vec %0d: state %0d valid %0d data %0h level %0d",
               i, state, rd_valid, rd_data, level);
      chk($sformatf("vec%0d state", i), 64'(state), 64'(vecs[i].st));
      chk($sformatf("vec%0d valid", i), 64'(rd_valid), 64'(vecs[i].rv));
      chk($sformatf("vec%0d level", i), 64'(level), 64'(vecs[i].lvl));
      if (vecs[i].rv)
        chk($sformatf("vec%0d data", i), 64'(rd_data), 64'(vecs[i].rd));
    end
    arm = 1'b0; trace_valid = 1'b0; trap = 1'b0; rd_ready = 1'b0;

    // Wrap: 12 pre-trigger words, only the last 5 survive plus 3 post words.
    do_arm();
    for (int i = 1; i <= 12; i++) push(DW'(i), 1'b0);
    do_trap();
    for (int i = 13; i <= 15; i++) push(DW'(i), 1'b0);
    drain("wrap", 36'h8, 8, 1'b0);

    // Coincident trigger: word 0x2 written with trap and counts as pre-trigger.
    do_arm();
    push(36'h1, 1'b0);
    push(36'h2, 1'b1);
    chk("coinc post state", 64'(state), 64'd2);
    for (int i = 3; i <= 5; i++) push(DW'(i), 1'b0);
    drain("coinc", 36'h1, 5, 1'b0);

    // Backpressure: basic stimulus, rd_ready toggled every cycle.
    do_arm();
    for (int i = 1; i <= 5; i++) push(DW'(i), 1'b0);
    do_trap();
    for (int i = 6; i <= 8; i++) push(DW'(i), 1'b0);
    drain("bp", 36'h1, 8, 1'b1);

    // Restart during POST after two post words, then a clean capture.
    do_arm();
    push(36'h1, 1'b0);
    push(36'h2, 1'b0);
    do_trap();
    push(36'h3, 1'b0);
    push(36'h4, 1'b0);
    chk("rearm pre state", 64'(state), 64'd2);
    do_arm();
    chk("rearm state", 64'(state), 64'd1);
    chk("rearm level", 64'(level), 64'd0);
    for (int i = 'h11; i <= 'h13; i++) push(DW'(i), 1'b0);
    do_trap();
    for (int i = 'h14; i <= 'h16; i++) push(DW'(i), 1'b0);
    drain("rearm", 36'h11, 6, 1'b0);

    // Asynchronous reset in the middle of POST, between clock edges.
    do_arm();
    push(36'h1, 1'b0);
    do_trap();
    push(36'h2, 1'b0);
    chk("areset pre state", 64'(state), 64'd2);
    #2 resetn = 1'b0;
    #1;
    chk("areset state", 64'(state), 64'd0);
    chk("areset valid", 64'(rd_valid), 64'd0);
    chk("areset level", 64'(level), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    cyc();
    chk("post-reset idle", 64'(state), 64'd0);
    push(36'h9, 1'b1);
    chk("post-reset ignore state", 64'(state), 64'd0);
    chk("post-reset ignore level", 64'(level), 64'd0);
    do_arm();
    chk("post-reset arm", 64'(state), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
